atrover_io_periph: RTL and testbench
====================================

Name: atrover_io_periph

Overview:
- Parametrised memory-mapped IO peripheral bank on the VexRiscv simple dBus, selected when address bit 31 = 1.
- Replaces the fixed 16-entry IO register array with a decoded register map.
- Provides: NUM_PWM gated PWM channels with shadowed duty, LED register, synchronised button/switch inputs, sticky write-1-to-clear button-edge flags, and a registered external interrupt output.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- PWM_FREQ, 20000, PWM frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ counts (5000 at defaults).
- NUM_PWM, 6, PWM channels, 1..8.
- NUM_LED, 4, LED outputs, 1..32.
- NUM_BTN, 4, button inputs, 1..32.
- NUM_SW, 4, switch inputs, 1..32.
- DATA_WL, 32, bus data width.
- ADDR_WL, 6, byte-offset bits decoded inside the IO window (16 words).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  dBus command valid; the top qualifies it with io_slct.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WL  byte address offset.
- cmd_data  in  DATA_WL  write data.
- cmd_size  in  2  0 = byte, 1 = half, 2 = word.
- cmd_ready  out  1  tied to 1.
- rsp_ready  out  1  read response valid.
- rsp_error  out  1  unmapped-address read.
- rsp_data  out  DATA_WL  read data.
- btn  in  NUM_BTN  debounced buttons, asynchronous to clk.
- sw  in  NUM_SW  switches, asynchronous to clk.
- leds  out  NUM_LED  LED drive.
- pwm_out  out  NUM_PWM  PWM outputs.
- irq  out  1  external interrupt, level.

Behaviour:
- Reset (async, rst_n = 0): all registers, synchroniser flops, counter, shadows and outputs = 0. rsp_ready = 0, irq = 0, pwm_out = 0, leds = 0.
- Register map (word index = cmd_addr[ADDR_WL-1:2]):
  - 0 ID: RO, 32'h4154_0001.
  - 1 LEDS: RW, [NUM_LED-1:0].
  - 2 PWM_EN: RW, [NUM_PWM-1:0].
  - 3 BTN: RO, synchronised level.
  - 4 BTN_EDGE: RW1C, sticky rising-edge flags.
  - 5 IRQ_EN: RW, [NUM_BTN-1:0].
  - 6 SW: RO, synchronised level.
  - 8..8+NUM_PWM-1 PWM_DUTY[i]: RW, 16 bits.
  - All other indices are unmapped.
- Register bits above a field's width read 0; writes to them are dropped.
- Writes use byte enables: size 0 → 4'b0001 << addr[1:0]; size 1 → 4'b0011 << addr[1:0]; else 4'b1111. Only enabled bytes update.
- Writes to RO or unmapped registers are ignored. Writes produce no response.
- Reads: rsp_ready = 1 exactly one cycle after cmd_valid && !cmd_wr.
  - rsp_data is registered, sampled at command time.
  - Unmapped read → rsp_data = 0, rsp_error = 1.
  - Back-to-back reads → back-to-back responses.
- Inputs: btn and sw pass through 2-flop synchronisers. BTN and SW reads return the synchronised value.
- Edge flags:
  - edge[i] sets on synchronised 0→1 of btn[i].
  - Writing 1 to BTN_EDGE[i] clears it.
  - Set and clear in the same cycle → set wins.
  - Reads never clear flags.
- PWM:
  - One shared counter 0..PERIOD-1, wraps to 0.
  - Per-channel shadow duty loads from PWM_DUTY[i] when the counter = PERIOD-1, so updates apply from the next period, glitch-free.
  - pwm_out[i] = PWM_EN[i] && (cnt < shadow[i]), registered.
  - Duty 0 → constant low; duty ≥ PERIOD → constant high.
  - Clearing PWM_EN[i] forces low on the next cycle.
- leds = LEDS register (direct register output, no added latency).

Optional Feature:
- Macro: ATROVER_IO_IRQ_EN.
- Defined: irq is registered as |(BTN_EDGE & IRQ_EN), so it asserts 1 cycle after the flag sets and deasserts 1 cycle after the last enabled flag clears. IRQ_EN is RW.
- Undefined: irq is tied 0. IRQ_EN reads 0 and ignores writes (register stays mapped, no error).

Decomposition:
- Package atrover_io_pkg holds:
  - io_reg_e enum for word indices;
  - IO_ID constant;
  - PWM_DUTY_BASE = 8;
  - byte-enable function.
- Sub-module atrover_pwm_chan: shadow register, compare and enable gating. Instantiated NUM_PWM times in a generate loop; the counter lives in the parent.

Test Plan:
- Read word 0 → next cycle rsp_ready = 1, rsp_data = 32'h4154_0001, rsp_error = 0.
- Read word 12 with NUM_PWM = 2 (unmapped) → rsp_error = 1, rsp_data = 0. Write 32'hFFFF_FFFF to word 0 then read → still 32'h4154_0001.
- Byte write 8'hA5 at byte offset 0x05 (LEDS, byte 1) with NUM_LED = 16 → LEDS = 16'hA500. leds follows on the next cycle.
- Pulse btn[2] 0→1 → BTN_EDGE = 4'b0100 three cycles later. With IRQ_EN = 4'b0100 and the macro defined, irq = 1 one cycle after that. Write 4'b0100 to BTN_EDGE → irq = 0 next cycle.
- New btn[1] edge in the same cycle as a W1C of bit 1 → flag remains 1.
- PERIOD = 5000, PWM_EN = 1, write DUTY[0] = 1250 mid-period → old duty holds until wrap, then high for exactly 1250 cycles per 5000. DUTY = 0 → always low; DUTY = 6000 → always high.

Source files
------------

// File: rtl/atrover_io_pkg.sv
// Shared definitions for the atrover IO peripheral: register word indices,
// the ID constant and the byte-lane helpers used by the write path.
package atrover_io_pkg;

    typedef enum logic [3:0] {
        REG_ID       = 4'd0,
        REG_LEDS     = 4'd1,
        REG_PWM_EN   = 4'd2,
        REG_BTN      = 4'd3,
        REG_BTN_EDGE = 4'd4,
        REG_IRQ_EN   = 4'd5,
        REG_SW       = 4'd6,
        REG_DUTY0    = 4'd8
    } io_reg_e;

    localparam logic [31:0] IO_ID         = 32'h4154_0001;
    localparam int          PWM_DUTY_BASE = 8;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/atrover_pwm_chan.sv
// One PWM channel: duty shadow reloaded at the end of each period, compare
// against the shared counter, enable gating and a registered output.
module atrover_pwm_chan #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [15:0]      duty,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
);

    logic [15:0] shadow_q, shadow_d;
    logic        pwm_q, pwm_d;

    // A duty at or above the period never loses the compare, giving a constant high.
    always_comb begin
        shadow_d = load ? duty : shadow_q;
        pwm_d    = en && (32'(cnt) < 32'(shadow_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/atrover_io_periph.sv
// Memory-mapped IO bank on the simple dBus: LEDs, PWM, synchronised buttons and
// switches, sticky W1C button-edge flags. Define ATROVER_IO_IRQ_EN to enable irq.
module atrover_io_periph
    import atrover_io_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int PWM_FREQ = 20000,
    parameter int NUM_PWM  = 6,
    parameter int NUM_LED  = 4,
    parameter int NUM_BTN  = 4,
    parameter int NUM_SW   = 4,
    parameter int DATA_WL  = 32,
    parameter int ADDR_WL  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic               cmd_wr,
    input  logic [ADDR_WL-1:0] cmd_addr,
    input  logic [DATA_WL-1:0] cmd_data,
    input  logic [1:0]         cmd_size,
    output logic               cmd_ready,
    output logic               rsp_ready,
    output logic               rsp_error,
    output logic [DATA_WL-1:0] rsp_data,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_LED-1:0] leds,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               irq
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic               rd_en, wr_en;
    logic [ADDR_WL-3:0] idx;
    int                 reg_idx;
    logic [3:0]         be;

    logic [NUM_LED-1:0] leds_q, leds_d;
    logic [NUM_PWM-1:0] pwm_en_q, pwm_en_d;
    logic [15:0]        duty_q [NUM_PWM];
    logic [15:0]        duty_d [NUM_PWM];
    logic [NUM_BTN-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
    logic [NUM_SW-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [NUM_BTN-1:0] edge_q, edge_d, edge_clr;
    logic [NUM_BTN-1:0] irq_en_rd;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pwm_load;

    logic [DATA_WL-1:0] rd_data;
    logic               rd_err;
    logic               rsp_ready_q, rsp_ready_d, rsp_error_q, rsp_error_d;
    logic [DATA_WL-1:0] rsp_data_q, rsp_data_d;

    assign rd_en   = cmd_valid && !cmd_wr;
    assign wr_en   = cmd_valid && cmd_wr;
    assign idx     = cmd_addr[ADDR_WL-1:2];
    assign reg_idx = int'(idx);
    assign be      = byte_en(cmd_size, cmd_addr[1:0]);

    always_comb begin
        leds_d     = leds_q;
        pwm_en_d   = pwm_en_q;
        duty_d     = duty_q;
        btn_s1_d   = btn;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        sw_s1_d    = sw;
        sw_s2_d    = sw_s1_q;
        edge_clr   = '0;
        if (wr_en) begin
            case (idx)
                REG_LEDS:     leds_d   = NUM_LED'(merge_bytes(32'(leds_q), cmd_data, be));
                REG_PWM_EN:   pwm_en_d = NUM_PWM'(merge_bytes(32'(pwm_en_q), cmd_data, be));
                REG_BTN_EDGE: edge_clr = NUM_BTN'(merge_bytes('0, cmd_data, be));
                default: ;
            endcase
            for (int i = 0; i < NUM_PWM; i++) begin
                if (reg_idx == PWM_DUTY_BASE + i) begin
                    duty_d[i] = 16'(merge_bytes(32'(duty_q[i]), cmd_data, be));
                end
            end
        end
        // A rising edge arriving with a W1C of the same bit must survive.
        edge_d = (edge_q & ~edge_clr) | (btn_s2_q & ~btn_prev_q);
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (idx)
            REG_ID:       rd_data = DATA_WL'(IO_ID);
            REG_LEDS:     rd_data = DATA_WL'(leds_q);
            REG_PWM_EN:   rd_data = DATA_WL'(pwm_en_q);
            REG_BTN:      rd_data = DATA_WL'(btn_s2_q);
            REG_BTN_EDGE: rd_data = DATA_WL'(edge_q);
            REG_IRQ_EN:   rd_data = DATA_WL'(irq_en_rd);
            REG_SW:       rd_data = DATA_WL'(sw_s2_q);
            default: begin
                rd_err = 1'b1;
                for (int i = 0; i < NUM_PWM; i++) begin
                    if (reg_idx == PWM_DUTY_BASE + i) begin
                        rd_err  = 1'b0;
                        rd_data = DATA_WL'(duty_q[i]);
                    end
                end
            end
        endcase
    end

    always_comb begin
        pwm_load    = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d       = pwm_load ? '0 : cnt_q + CNT_W'(1);
        rsp_ready_d = rd_en;
        rsp_error_d = rd_en && rd_err;
        rsp_data_d  = rd_en ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q      <= '0;
            pwm_en_q    <= '0;
            duty_q      <= '{default: '0};
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_prev_q  <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            edge_q      <= '0;
            cnt_q       <= '0;
            rsp_ready_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            leds_q      <= leds_d;
            pwm_en_q    <= pwm_en_d;
            duty_q      <= duty_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_prev_q  <= btn_prev_d;
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            rsp_ready_q <= rsp_ready_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef ATROVER_IO_IRQ_EN
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic               irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && idx == REG_IRQ_EN) begin
            irq_en_d = NUM_BTN'(merge_bytes(32'(irq_en_q), cmd_data, be));
        end
        irq_d = |(edge_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = '0;
`endif

    for (genvar g = 0; g < NUM_PWM; g++) begin : g_pwm
        atrover_pwm_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (pwm_load),
            .en     (pwm_en_q[g]),
            .duty   (duty_q[g]),
            .cnt    (cnt_q),
            .pwm_out(pwm_out[g])
        );
    end

    assign cmd_ready = 1'b1;
    assign rsp_ready = rsp_ready_q;
    assign rsp_error = rsp_error_q;
    assign rsp_data  = rsp_data_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_atrover_io_periph.sv
// Bench for atrover_io_periph: vector table, directed edge/irq/PWM sequences and
// randomized bus traffic checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_atrover_io_periph;

    localparam int NUM_PWM = 2;
    localparam int NUM_LED = 16;
    localparam int NUM_BTN = 4;
    localparam int NUM_SW  = 4;
`ifdef ATROVER_IO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid, cmd_wr;
    logic [5:0]         cmd_addr;
    logic [31:0]        cmd_data;
    logic [1:0]         cmd_size;
    logic               cmd_ready, rsp_ready, rsp_error, irq;
    logic [31:0]        rsp_data;
    logic [NUM_BTN-1:0] btn;
    logic [NUM_SW-1:0]  sw;
    logic [NUM_LED-1:0] leds;
    logic [NUM_PWM-1:0] pwm_out;

    atrover_io_periph #(
        .NUM_PWM(NUM_PWM), .NUM_LED(NUM_LED), .NUM_BTN(NUM_BTN), .NUM_SW(NUM_SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
        .cmd_ready(cmd_ready), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
        .rsp_data(rsp_data), .btn(btn), .sw(sw), .leds(leds), .pwm_out(pwm_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_leds, m_pwm_en, m_edge, m_irq_en;
    logic [31:0] m_duty [NUM_PWM];
    logic [3:0]  bh [4];
    logic [3:0]  sh [4];

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;
    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        int first, n;
        r     = old;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        first = (sz >= 2'd2) ? 0 : int'(off);
        for (int b = first; b < first + n && b < 4; b++) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Returns {error, data} for a read issued while the model holds its current state.
    function automatic logic [32:0] model_read(input logic [5:0] a);
        case (a[5:2])
            4'd0:    return {1'b0, 32'h4154_0001};
            4'd1:    return {1'b0, m_leds};
            4'd2:    return {1'b0, m_pwm_en};
            4'd3:    return {1'b0, 28'd0, bh[2]};
            4'd4:    return {1'b0, m_edge};
            4'd5:    return {1'b0, IRQ_ON ? m_irq_en : 32'd0};
            4'd6:    return {1'b0, 28'd0, sh[2]};
            4'd8:    return {1'b0, m_duty[0]};
            4'd9:    return {1'b0, m_duty[1]};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // One clock: predict from the model, advance the model, sample #1 after the edge.
    task automatic tick();
        logic        exp_rd, exp_err, exp_irq;
        logic [31:0] exp_data, clr;
        logic [3:0]  rise;
        for (int k = 3; k > 0; k--) begin
            bh[k] = bh[k-1];
            sh[k] = sh[k-1];
        end
        bh[0] = btn;
        sh[0] = sw;
        exp_rd = cmd_valid && !cmd_wr;
        {exp_err, exp_data} = exp_rd ? model_read(cmd_addr) : 33'd0;
        exp_irq = IRQ_ON && (|(m_edge & m_irq_en));
        rise    = bh[2] & ~bh[3];
        if (cmd_valid && cmd_wr) begin
            case (cmd_addr[5:2])
                4'd1: m_leds   = lane_write(m_leds, cmd_data, cmd_size, cmd_addr[1:0]) & 32'hFFFF;
                4'd2: m_pwm_en = lane_write(m_pwm_en, cmd_data, cmd_size, cmd_addr[1:0]) & 32'h3;
                4'd4: begin
                    clr    = lane_write(32'd0, cmd_data, cmd_size, cmd_addr[1:0]) & 32'hF;
                    m_edge = m_edge & ~clr;
                end
                4'd5: if (IRQ_ON) m_irq_en = lane_write(m_irq_en, cmd_data, cmd_size, cmd_addr[1:0]) & 32'hF;
                4'd8: m_duty[0] = lane_write(m_duty[0], cmd_data, cmd_size, cmd_addr[1:0]) & 32'hFFFF;
                4'd9: m_duty[1] = lane_write(m_duty[1], cmd_data, cmd_size, cmd_addr[1:0]) & 32'hFFFF;
                default: ;
            endcase
        end
        m_edge = m_edge | {28'd0, rise};
        @(posedge clk);
        #1;
        chk("rsp_ready", {31'd0, rsp_ready}, {31'd0, exp_rd});
        if (exp_rd) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        end
        chk("irq", {31'd0, irq}, {31'd0, exp_irq});
        chk("leds", {16'd0, leds}, m_leds);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_size  = sz;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi, got, s1249, s1250, first_hi;
        logic prev;

        tbl[0]  = '{1'b0, 6'h00, 2'd2, 32'h0,         32'h4154_0001, 1'b0};
        tbl[1]  = '{1'b1, 6'h00, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 6'h00, 2'd2, 32'h0,         32'h4154_0001, 1'b0};
        tbl[3]  = '{1'b0, 6'h30, 2'd2, 32'h0,         32'h0,         1'b1};
        tbl[4]  = '{1'b1, 6'h05, 2'd0, 32'hA5A5_A5A5, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 6'h04, 2'd2, 32'h0,         32'h0000_A500, 1'b0};
        tbl[6]  = '{1'b1, 6'h04, 2'd2, 32'hFFFF_1234, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 6'h04, 2'd2, 32'h0,         32'h0000_1234, 1'b0};
        tbl[8]  = '{1'b1, 6'h08, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[9]  = '{1'b0, 6'h08, 2'd2, 32'h0,         32'h0000_0003, 1'b0};
        tbl[10] = '{1'b1, 6'h20, 2'd2, 32'h1234_5678, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 6'h20, 2'd2, 32'h0,         32'h0000_5678, 1'b0};
        tbl[12] = '{1'b1, 6'h22, 2'd1, 32'hBEEF_BEEF, 32'h0,         1'b0};
        tbl[13] = '{1'b0, 6'h20, 2'd2, 32'h0,         32'h0000_5678, 1'b0};
        tbl[14] = '{1'b1, 6'h21, 2'd0, 32'hABAB_ABAB, 32'h0,         1'b0};
        tbl[15] = '{1'b0, 6'h20, 2'd2, 32'h0,         32'h0000_AB78, 1'b0};
        tbl[16] = '{1'b0, 6'h1C, 2'd2, 32'h0,         32'h0,         1'b1};
        tbl[17] = '{1'b0, 6'h18, 2'd2, 32'h0,         32'h0000_000A, 1'b0};
        tbl[18] = '{1'b1, 6'h14, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[19] = '{1'b0, 6'h14, 2'd2, 32'h0,         IRQ_ON ? 32'hF : 32'h0, 1'b0};
        tbl[20] = '{1'b1, 6'h08, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[21] = '{1'b0, 6'h24, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[22] = '{1'b0, 6'h0C, 2'd2, 32'h0,         32'h0,         1'b0};

        m_leds = 0; m_pwm_en = 0; m_edge = 0; m_irq_en = 0;
        m_duty[0] = 0; m_duty[1] = 0;
        for (int k = 0; k < 4; k++) begin bh[k] = 4'd0; sh[k] = 4'd0; end

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
        cmd_data = '0; cmd_size = 2'd2; btn = 4'd0; sw = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_leds", {16'd0, leds}, 32'd0);
        chk("reset_pwm", {30'd0, pwm_out}, 32'd0);
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        idle(4);

        for (int v = 0; v < 23; v++) begin
            bus(tbl[v].wr, tbl[v].addr, tbl[v].data, tbl[v].size);
            if (!tbl[v].wr) begin
                chk($sformatf("tbl%0d_data", v), rsp_data, tbl[v].exp);
                chk($sformatf("tbl%0d_err", v), {31'd0, rsp_error}, {31'd0, tbl[v].exp_err});
            end
        end

        // Button edge -> flag -> irq, then W1C
        bus(1'b1, 6'h14, 32'h4, 2'd2);
        bus(1'b1, 6'h10, 32'hF, 2'd2);
        idle(4);
        btn = 4'b0100;
        idle(3);
        chk("edge_irq_early", {31'd0, irq}, 32'd0);
        idle(1);
        chk("edge_irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        bus(1'b0, 6'h10, 32'h0, 2'd2);
        chk("edge_flag", rsp_data, 32'h4);
        bus(1'b1, 6'h10, 32'h4, 2'd2);
        chk("edge_irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
        idle(1);
        chk("edge_irq_clear", {31'd0, irq}, 32'd0);
        bus(1'b0, 6'h10, 32'h0, 2'd2);
        chk("edge_flag_cleared", rsp_data, 32'h0);

        // New edge on btn[1] coinciding with its W1C: set wins
        btn = 4'b0110;
        idle(2);
        bus(1'b1, 6'h10, 32'h2, 2'd2);
        bus(1'b0, 6'h10, 32'h0, 2'd2);
        chk("set_wins", rsp_data, 32'h2);
        bus(1'b1, 6'h10, 32'h2, 2'd2);
        btn = 4'b0000;
        idle(4);
        bus(1'b0, 6'h10, 32'h0, 2'd2);
        chk("fall_no_flag", rsp_data, 32'h0);

        // Randomized traffic against the model
        for (int r = 0; r < 1500; r++) begin
            if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
            if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_wr    = $urandom_range(0, 1) == 1;
            cmd_addr  = 6'($urandom_range(0, 63));
            cmd_size  = 2'($urandom_range(0, 3));
            cmd_data  = $urandom;
            tick();
        end
        cmd_valid = 1'b0;

        // PWM: mid-period duty change, then duty 0 and duty above the period
        bus(1'b1, 6'h08, 32'h1, 2'd2);
        bus(1'b1, 6'h24, 32'h0, 2'd2);
        bus(1'b1, 6'h20, 32'd2500, 2'd2);
        idle(5001);
        got = 0;
        for (int k = 0; k < 6000 && got == 0; k++) begin
            prev = pwm_out[0];
            tick();
            if (!prev && pwm_out[0]) got = 1;
        end
        chk("pwm_align", got, 1);
        hi = int'(pwm_out[0]);
        for (int k = 1; k < 5000; k++) begin
            if (k == 100) bus(1'b1, 6'h20, 32'd1250, 2'd2);
            else tick();
            hi += int'(pwm_out[0]);
        end
        chk("pwm_old_duty", hi, 2500);
        hi = 0; s1249 = 0; s1250 = 0; first_hi = 0;
        for (int k = 0; k < 5000; k++) begin
            tick();
            hi += int'(pwm_out[0]);
            if (k == 0) first_hi = int'(pwm_out[0]);
            if (k == 1249) s1249 = int'(pwm_out[0]);
            if (k == 1250) s1250 = int'(pwm_out[0]);
        end
        chk("pwm_new_duty", hi, 1250);
        chk("pwm_first_high", first_hi, 1);
        chk("pwm_last_high", s1249, 1);
        chk("pwm_first_low", s1250, 0);
        chk("pwm_ch1_off", {31'd0, pwm_out[1]}, 32'd0);

        bus(1'b1, 6'h20, 32'd0, 2'd2);
        idle(5001);
        hi = 0;
        for (int k = 0; k < 5000; k++) begin tick(); hi += int'(pwm_out[0]); end
        chk("pwm_duty0", hi, 0);

        bus(1'b1, 6'h20, 32'd6000, 2'd2);
        idle(5001);
        hi = 0;
        for (int k = 0; k < 5000; k++) begin tick(); hi += int'(pwm_out[0]); end
        chk("pwm_duty_full", hi, 5000);

        bus(1'b1, 6'h08, 32'h0, 2'd2);
        idle(1);
        chk("pwm_disable", {30'd0, pwm_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
